// File: rtl/rice_core_register_file_mp_if.sv
// rice_core_register_file_mp_if: read, write-back, issue and debug bundle for the multi-port register file
interface rice_core_register_file_mp_if #(
    parameter int XLEN        = 32,
    parameter int RF_SIZE     = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1
);
    localparam int AW = $clog2(RF_SIZE);
    logic [READ_PORTS-1:0][AW-1:0]    i_rd_addr;
    logic [READ_PORTS-1:0][XLEN-1:0]  o_rd_value;
    logic [READ_PORTS-1:0]            o_rd_busy;
    logic [WRITE_PORTS-1:0]           i_wb_valid;
    logic [WRITE_PORTS-1:0][AW-1:0]   i_wb_rd;
    logic [WRITE_PORTS-1:0][XLEN-1:0] i_wb_value;
    logic                             i_issue_valid;
    logic [AW-1:0]                    i_issue_rd;
    logic                             i_flush;
    logic                             i_dbg_req;
    logic [AW-1:0]                    i_dbg_addr;
    logic                             o_dbg_ack;
    logic [XLEN-1:0]                  o_dbg_value;
    modport master (
        output i_rd_addr, i_wb_valid, i_wb_rd, i_wb_value, i_issue_valid, i_issue_rd,
               i_flush, i_dbg_req, i_dbg_addr,
        input  o_rd_value, o_rd_busy, o_dbg_ack, o_dbg_value
    );
    modport slave (
        input  i_rd_addr, i_wb_valid, i_wb_rd, i_wb_value, i_issue_valid, i_issue_rd,
               i_flush, i_dbg_req, i_dbg_addr,
        output o_rd_value, o_rd_busy, o_dbg_ack, o_dbg_value
    );
endinterface

// File: rtl/rice_core_register_file_mp.sv
// rice_core_register_file_mp: multi-port register file with write-back bypass, busy scoreboard and debug read
module rice_core_register_file_mp #(
    parameter int XLEN        = 32,
    parameter int RF_SIZE     = 32,
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1
) (
    input logic i_clk,
    input logic i_rst_n,
    rice_core_register_file_mp_if.slave bus
);
    localparam int AW = $clog2(RF_SIZE);
    localparam logic [AW:0] RF_LIM = RF_SIZE[AW:0];

    // Address names a real, writable register: not x0 and inside the file (matters for RV32E-style sizes).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < RF_LIM);
    endfunction

    logic [XLEN-1:0]        regs_q [RF_SIZE];
    logic [XLEN-1:0]        regs_d [RF_SIZE];
    logic [RF_SIZE-1:0]     busy_q, busy_d;
    logic [RF_SIZE-1:0]     wb_hit, iss_hit;
    logic [WRITE_PORTS-1:0] wb_ok;
    logic                   dbg_ack_q;
    logic [XLEN-1:0]        dbg_value_q;

    // Next storage and scoreboard state; later write ports overwrite earlier ones so the highest index wins.
    always_comb begin
        regs_d  = regs_q;
        wb_hit  = '0;
        iss_hit = '0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
            wb_ok[p] = bus.i_wb_valid[p] && addr_ok(bus.i_wb_rd[p]);
            if (wb_ok[p]) begin
                regs_d[bus.i_wb_rd[p]] = bus.i_wb_value[p];
                wb_hit[bus.i_wb_rd[p]] = 1'b1;
            end
        end
        if (bus.i_issue_valid && addr_ok(bus.i_issue_rd))
            iss_hit[bus.i_issue_rd] = 1'b1;
        busy_d = bus.i_flush ? '0 : (iss_hit | (busy_q & ~wb_hit));
    end

    // Storage and busy bits; reset discards anything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < RF_SIZE; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar r = 0; r < READ_PORTS; r++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] fwd;
        assign a = bus.i_rd_addr[r];
        // Stored value, overridden by any same-cycle write-back to the same register (highest port wins).
        always_comb begin
            fwd = regs_q[a];
            for (int p = 0; p < WRITE_PORTS; p++)
                if (wb_ok[p] && bus.i_wb_rd[p] == a) fwd = bus.i_wb_value[p];
        end
        assign bus.o_rd_value[r] = addr_ok(a) ? fwd : '0;
        assign bus.o_rd_busy[r]  = addr_ok(a) && busy_q[a] && !wb_hit[a];
    end

    // Debug read samples storage (never the bypass) and presents it one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dbg_ack_q   <= 1'b0;
            dbg_value_q <= '0;
        end else begin
            dbg_ack_q <= bus.i_dbg_req;
            if (bus.i_dbg_req)
                dbg_value_q <= addr_ok(bus.i_dbg_addr) ? regs_q[bus.i_dbg_addr] : '0;
        end
    end

    assign bus.o_dbg_ack   = dbg_ack_q;
    assign bus.o_dbg_value = dbg_value_q;
endmodule

// File: tb/tb_rice_core_register_file_mp.sv
// tb_rice_core_register_file_mp: directed checks of reads, bypass, conflicts, scoreboard, debug and reset
module tb_rice_core_register_file_mp;
    localparam int XLEN = 32, RF_SIZE = 16, RP = 3, WP = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rice_core_register_file_mp_if #(.XLEN(XLEN), .RF_SIZE(RF_SIZE), .READ_PORTS(RP), .WRITE_PORTS(WP)) bus ();

    rice_core_register_file_mp #(.XLEN(XLEN), .RF_SIZE(RF_SIZE), .READ_PORTS(RP), .WRITE_PORTS(WP)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input int p, input logic [3:0] rd, input logic [31:0] v);
        bus.i_wb_valid[p] = 1'b1;
        bus.i_wb_rd[p]    = rd;
        bus.i_wb_value[p] = v;
        #1;
    endtask

    task automatic idle();
        bus.i_wb_valid    = '0;
        bus.i_issue_valid = 1'b0;
        bus.i_flush       = 1'b0;
        bus.i_dbg_req     = 1'b0;
        #1;
    endtask

    initial begin
        bus.i_rd_addr = '0; bus.i_wb_valid = '0; bus.i_wb_rd = '0; bus.i_wb_value = '0;
        bus.i_issue_valid = 1'b0; bus.i_issue_rd = '0; bus.i_flush = 1'b0;
        bus.i_dbg_req = 1'b0; bus.i_dbg_addr = '0;
        #1;
        chk("reset_rd0", bus.o_rd_value[0], 0);
        chk("reset_ack", bus.o_dbg_ack, 0);
        #11 rst_n = 1'b1;
        tick();

        bus.i_rd_addr[0] = 4'd5;
        wb(0, 4'd5, 32'hDEAD_BEEF);
        chk("bypass_x5", bus.o_rd_value[0], 32'hDEAD_BEEF);
        tick(); idle();
        chk("stored_x5", bus.o_rd_value[0], 32'hDEAD_BEEF);
        chk("busy_x5", bus.o_rd_busy[0], 0);

        bus.i_rd_addr[1] = 4'd0;
        wb(0, 4'd0, 32'h1234);
        chk("x0_bypass", bus.o_rd_value[1], 0);
        tick(); idle();
        chk("x0_stored", bus.o_rd_value[1], 0);

        bus.i_rd_addr[2] = 4'd7;
        wb(0, 4'd7, 32'h11);
        wb(1, 4'd7, 32'h22);
        chk("conflict_bypass", bus.o_rd_value[2], 32'h22);
        tick(); idle();
        chk("conflict_stored", bus.o_rd_value[2], 32'h22);

        bus.i_rd_addr[0] = 4'd3;
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 4'd3; #1;
        chk("busy_issue_cycle", bus.o_rd_busy[0], 0);
        tick(); idle();
        chk("busy_after_issue", bus.o_rd_busy[0], 1);
        wb(0, 4'd3, 32'h55);
        chk("busy_wb_same", bus.o_rd_busy[0], 0);
        chk("value_wb_same", bus.o_rd_value[0], 32'h55);
        tick(); idle();
        chk("busy_after_wb", bus.o_rd_busy[0], 0);
        chk("value_after_wb", bus.o_rd_value[0], 32'h55);
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 4'd3;
        wb(0, 4'd3, 32'h66);
        tick(); idle();
        chk("busy_issue_wb", bus.o_rd_busy[0], 1);
        chk("value_issue_wb", bus.o_rd_value[0], 32'h66);
        bus.i_flush = 1'b1;
        bus.i_rd_addr[1] = 4'd4;
        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 4'd4; #1;
        chk("busy_flush_cycle", bus.o_rd_busy[0], 1);
        tick(); idle();
        chk("busy_after_flush", bus.o_rd_busy[0], 0);
        chk("flush_over_issue", bus.o_rd_busy[1], 0);

        wb(0, 4'd9, 32'hA5A5_A5A5);
        tick(); idle();
        bus.i_dbg_req = 1'b1; bus.i_dbg_addr = 4'd9; #1;
        chk("dbg_ack_early", bus.o_dbg_ack, 0);
        tick(); idle();
        chk("dbg_ack", bus.o_dbg_ack, 1);
        chk("dbg_value", bus.o_dbg_value, 32'hA5A5_A5A5);
        tick();
        chk("dbg_ack_pulse", bus.o_dbg_ack, 0);
        chk("dbg_hold", bus.o_dbg_value, 32'hA5A5_A5A5);
        bus.i_dbg_req = 1'b1; bus.i_dbg_addr = 4'd9;
        wb(0, 4'd9, 32'h1);
        tick(); idle();
        chk("dbg_no_bypass", bus.o_dbg_value, 32'hA5A5_A5A5);
        bus.i_dbg_req = 1'b1; bus.i_dbg_addr = 4'd9; #1;
        tick();
        chk("dbg_b2b_ack1", bus.o_dbg_ack, 1);
        chk("dbg_b2b_val1", bus.o_dbg_value, 32'h1);
        bus.i_dbg_addr = 4'd5; #1;
        tick();
        chk("dbg_b2b_ack2", bus.o_dbg_ack, 1);
        chk("dbg_b2b_val2", bus.o_dbg_value, 32'hDEAD_BEEF);
        bus.i_dbg_addr = 4'd0; #1;
        tick(); idle();
        chk("dbg_x0", bus.o_dbg_value, 0);
        tick();
        chk("dbg_idle_ack", bus.o_dbg_ack, 0);

        wb(0, 4'd1, 32'h111);
        wb(1, 4'd2, 32'h222);
        tick(); idle();
        wb(0, 4'd15, 32'hF0F);
        tick(); idle();
        bus.i_rd_addr[0] = 4'd1; bus.i_rd_addr[1] = 4'd2; bus.i_rd_addr[2] = 4'd15; #1;
        chk("rv32e_x1", bus.o_rd_value[0], 32'h111);
        chk("rv32e_x2", bus.o_rd_value[1], 32'h222);
        chk("rv32e_x15", bus.o_rd_value[2], 32'hF0F);

        bus.i_issue_valid = 1'b1; bus.i_issue_rd = 4'd2;
        bus.i_dbg_req = 1'b1; bus.i_dbg_addr = 4'd1; #1;
        tick(); idle();
        chk("pre_reset_busy", bus.o_rd_busy[1], 1);
        chk("pre_reset_ack", bus.o_dbg_ack, 1);
        wb(0, 4'd8, 32'h88);
        rst_n = 1'b0; #1;
        chk("async_rd0", bus.o_rd_value[0], 0);
        chk("async_rd1", bus.o_rd_value[1], 0);
        chk("async_rd2", bus.o_rd_value[2], 0);
        chk("async_busy", bus.o_rd_busy, 0);
        chk("async_ack", bus.o_dbg_ack, 0);
        chk("async_dbg_val", bus.o_dbg_value, 0);
        tick(); idle();
        rst_n = 1'b1;
        bus.i_rd_addr[0] = 4'd8; #1;
        chk("reset_drops_wb", bus.o_rd_value[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
